// File: rtl/dsp_share_pkg.sv
// dsp_share_pkg: opcode and in-flight tag types shared by the DSP arbiter slice
package dsp_share_pkg;
  localparam int TAG_ID_W = 8;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOR  = 3'd6,
    OP_RSVD = 3'd7
  } dsp_op_t;
  typedef struct packed {
    logic [TAG_ID_W-1:0] id;
    logic                err;
  } tag_t;
  // the reserved opcode travels through the DSP as a harmless add
  function automatic logic [2:0] issue_op(input logic [2:0] op);
    return op == OP_RSVD ? OP_ADD : op;
  endfunction
endpackage

// File: rtl/dsp_share_resp_fifo.sv
// dsp_share_resp_fifo: first-word-fall-through response FIFO exposing its occupancy
module dsp_share_resp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign valid = count != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/dsp_share_arbiter.sv
// dsp_share_arbiter: round-robin sharing of one pipelined DSP ALU with in-order, credit-guarded responses
module dsp_share_arbiter
  import dsp_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int DSP_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*3-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     dsp_valid,
  output logic [2:0]               dsp_op,
  output logic [WIDTH-1:0]         dsp_a,
  output logic [WIDTH-1:0]         dsp_b,
  input  logic [WIDTH-1:0]         dsp_y,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_err,
  output logic [WIDTH-1:0]         resp_y
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $bits(tag_t) + WIDTH;
  logic [ID_W-1:0]        ptr, gnt_id;
  logic                   gnt_hit, hs, push, pop, fifo_valid, unused_id;
  logic [CW-1:0]          count, inflight, credits;
  logic [2:0]             op_sel;
  logic [WIDTH-1:0]       a_sel, b_sel, head_y;
  logic [FW-1:0]          fifo_dout;
  tag_t                   iss_tag, head_tag, exit_tag;
  tag_t                   pipe_tag [DSP_LATENCY];
  logic [DSP_LATENCY-1:0] pipe_vld;
  // lowest rotation offset from ptr wins, so iterate from the far end
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
        gnt_hit = 1'b1;
        gnt_id = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
  end
  always_comb begin
    op_sel = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_id == ID_W'(i)) begin
        op_sel = req_op[3*i +: 3];
        a_sel = req_a[WIDTH*i +: WIDTH];
        b_sel = req_b[WIDTH*i +: WIDTH];
      end
  end
  // every slot is either free, in the DSP pipe, or waiting in the FIFO
  assign credits = CW'(FIFO_DEPTH) - count - inflight;
  assign hs = gnt_hit & (credits != '0);
  assign req_ready = hs ? NUM_REQ'(1) << gnt_id : '0;
  assign exit_tag = pipe_tag[DSP_LATENCY-1];
  assign push = pipe_vld[DSP_LATENCY-1];
  assign pop = fifo_valid & resp_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      inflight <= '0;
      dsp_valid <= 1'b0;
      dsp_op <= OP_ADD;
      dsp_a <= '0;
      dsp_b <= '0;
      iss_tag <= '0;
      pipe_vld <= '0;
      for (int k = 0; k < DSP_LATENCY; k++) pipe_tag[k] <= '0;
    end else begin
      dsp_valid <= hs;
      inflight <= inflight + CW'(hs) - CW'(push);
      pipe_vld <= DSP_LATENCY'({pipe_vld, dsp_valid});
      pipe_tag[0] <= iss_tag;
      for (int k = 1; k < DSP_LATENCY; k++) pipe_tag[k] <= pipe_tag[k-1];
      if (hs) begin
        ptr <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
        dsp_op <= issue_op(op_sel);
        dsp_a <= a_sel;
        dsp_b <= b_sel;
        iss_tag <= '{id: TAG_ID_W'(gnt_id), err: op_sel == OP_RSVD};
      end
    end
  end
  dsp_share_resp_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({exit_tag, dsp_y & {WIDTH{~exit_tag.err}}}),
    .dout(fifo_dout),
    .valid(fifo_valid),
    .count(count)
  );
  assign {head_tag, head_y} = fifo_dout;
  assign unused_id = ^head_tag.id;
  // the FIFO array is not reset, so mask the head while empty
  assign resp_valid = fifo_valid;
  assign resp_id = fifo_valid ? head_tag.id[ID_W-1:0] : '0;
  assign resp_err = fifo_valid & head_tag.err;
  assign resp_y = fifo_valid ? head_y : '0;
endmodule

// File: tb/tb_dsp_share_arbiter.sv
// tb_dsp_share_arbiter: directed checks of arbitration, credits, ordering and reset of dsp_share_arbiter
module tb_dsp_share_arbiter;
  import dsp_share_pkg::*;
  localparam int W = 32, N = 4, L = 2, D = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*3-1:0] req_op;
  logic [N*W-1:0] req_a, req_b;
  logic dsp_valid, resp_valid, resp_err;
  logic resp_ready = 1'b0;
  logic [2:0] dsp_op;
  logic [W-1:0] dsp_a, dsp_b, dsp_y, resp_y;
  logic [1:0] resp_id;
  logic [2:0] op_v [N];
  logic [W-1:0] a_v [N], b_v [N], dsp_st [L];
  logic [W-1:0] exp2 [4] = '{32'd11, 32'd9, 32'hfffffd03, 32'hfffffff4};
  logic [W-1:0] exp4 [7] = '{32'd200, 32'd201, 32'd202, 32'd203, 32'd300, 32'd301, 32'd302};
  int exp4_id [7] = '{0, 0, 0, 0, 1, 1, 1};
  int checks = 0, errors = 0, cyc = 0, seen;
  typedef struct {int cyc; int id;} hs_t;
  typedef struct {int cyc; int id; logic err; logic [W-1:0] y;} rsp_t;
  hs_t hs_q[$];
  rsp_t rsp_q[$];

  always #5 clock = ~clock;

  dsp_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .DSP_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_y(dsp_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_err(resp_err), .resp_y(resp_y)
  );

  always_comb
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3] = op_v[i];
      req_a[W*i +: W] = a_v[i];
      req_b[W*i +: W] = b_v[i];
    end

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_NOR: return ~(a | b);
      default: return a + b;
    endcase
  endfunction

  assign dsp_y = dsp_st[L-1];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    dsp_st[0] <= alu(dsp_op, dsp_a, dsp_b);
    for (int k = 1; k < L; k++) dsp_st[k] <= dsp_st[k-1];
  end

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) hs_q.push_back('{cyc, i});
    if (resp_valid && resp_ready) rsp_q.push_back('{cyc, int'(resp_id), resp_err, resp_y});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    hs_q.delete();
    rsp_q.delete();
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int t = 0; t < 60 && rsp_q.size() < n; t++) tick();
    check({tag, " rsp count"}, rsp_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      op_v[i] = OP_ADD;
      a_v[i] = '0;
      b_v[i] = '0;
    end
    tick();
    tick();
    check("reset dsp", {dsp_valid, dsp_op, dsp_a}, '0);
    check("reset dsp_b", dsp_b, '0);
    check("reset resp", {resp_valid, resp_id, resp_err, resp_y, req_ready}, '0);
    // single add, latency from handshake to response
    reset = 1'b0;
    resp_ready = 1'b1;
    a_v[0] = 32'd1;
    b_v[0] = 32'hffff0001;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    check("t1 hs", hs_q.size(), 1);
    wait_rsp(1, "t1");
    check("t1 y", rsp_q[0].y, 32'hffff0002);
    check("t1 id/err", {rsp_q[0].id, rsp_q[0].err}, 0);
    check("t1 latency", rsp_q[0].cyc - hs_q[0].cyc, L + 2);
    // four requesters held valid: rotation 0..3 on consecutive cycles
    do_reset();
    op_v = '{OP_ADD, OP_SUB, OP_MUL, OP_NOR};
    a_v = '{32'd10, 32'd10, 32'hffffff01, 32'd10};
    b_v = '{32'd1, 32'd1, 32'd3, 32'd1};
    req_valid = 4'hf;
    repeat (4) tick();
    req_valid = '0;
    check("t2 hs", hs_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t2 grant", hs_q[k].id, k);
      check("t2 grant cyc", hs_q[k].cyc - hs_q[0].cyc, k);
    end
    wait_rsp(4, "t2");
    for (int k = 0; k < 4; k++) begin
      check("t2 y", rsp_q[k].y, exp2[k]);
      check("t2 id", rsp_q[k].id, k);
    end
    // back-pressure exhausts the credits
    hs_q.delete();
    rsp_q.delete();
    resp_ready = 1'b0;
    op_v[0] = OP_ADD;
    a_v[0] = 32'd100;
    b_v[0] = 32'd1;
    req_valid = 4'b0001;
    repeat (12) begin
      tick();
      a_v[0] = 100 + hs_q.size();
    end
    check("t3 hs stall", hs_q.size(), D);
    check("t3 ready stall", req_ready, 0);
    check("t3 resp held", {resp_valid, 1'(rsp_q.size())}, 2'b10);
    resp_ready = 1'b1;
    for (int t = 0; t < 40 && hs_q.size() < 8; t++) begin
      tick();
      a_v[0] = 100 + hs_q.size();
    end
    req_valid = '0;
    check("t3 hs total", hs_q.size(), 8);
    wait_rsp(8, "t3");
    for (int k = 0; k < 8; k++) check("t3 y", {rsp_q[k].id, rsp_q[k].y}, {32'd0, 32'(101 + k)});
    repeat (6) tick();
    check("t3 no dup", rsp_q.size(), 8);
    // full FIFO: a pop and an issue in the same cycle keep credits steady
    do_reset();
    resp_ready = 1'b0;
    a_v[0] = 32'd200;
    b_v[0] = 32'd0;
    req_valid = 4'b0001;
    for (int t = 0; t < 20 && hs_q.size() < 4; t++) begin
      tick();
      a_v[0] = 200 + hs_q.size();
    end
    req_valid = '0;
    repeat (L + 3) tick();
    check("t4 full", {resp_valid, req_ready}, 5'b10000);
    hs_q.delete();
    op_v[1] = OP_ADD;
    a_v[1] = 32'd300;
    b_v[1] = 32'd0;
    req_valid = 4'b0010;
    resp_ready = 1'b1;
    for (int t = 0; t < 20 && hs_q.size() < 3; t++) begin
      tick();
      a_v[1] = 300 + hs_q.size();
    end
    req_valid = '0;
    check("t4 hs", hs_q.size(), 3);
    wait_rsp(7, "t4");
    check("t4 first issue", hs_q[0].cyc - rsp_q[0].cyc, 1);
    check("t4 pop+issue", rsp_q[1].cyc - hs_q[0].cyc, 0);
    check("t4 issue 2", hs_q[1].cyc - hs_q[0].cyc, 1);
    check("t4 issue 3", hs_q[2].cyc - hs_q[0].cyc, 2);
    for (int k = 0; k < 7; k++) check("t4 order", {rsp_q[k].id, rsp_q[k].y}, {32'(exp4_id[k]), exp4[k]});
    // reserved opcode
    do_reset();
    op_v[2] = 3'd7;
    a_v[2] = 32'd5;
    b_v[2] = 32'd6;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("t5 hs", hs_q.size(), 1);
    check("t5 issued op", {dsp_valid, dsp_op, dsp_a}, {1'b1, 3'd0, 32'd5});
    wait_rsp(1, "t5");
    check("t5 resp", {rsp_q[0].id, rsp_q[0].err, rsp_q[0].y}, {32'd2, 1'b1, 32'd0});
    // reset with operations in flight
    do_reset();
    op_v = '{OP_ADD, OP_ADD, OP_ADD, OP_ADD};
    a_v = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_v = '{32'd0, 32'd0, 32'd0, 32'd0};
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    check("t6 hs", hs_q.size(), 3);
    tick();
    reset = 1'b1;
    tick();
    check("t6 reset dsp", {dsp_valid, dsp_op, dsp_a, req_ready}, '0);
    check("t6 reset resp", {resp_valid, resp_id, resp_err, resp_y}, '0);
    reset = 1'b0;
    hs_q.delete();
    rsp_q.delete();
    seen = 0;
    repeat (10) begin
      tick();
      if (resp_valid) seen++;
    end
    check("t6 no stale", {32'(seen), 32'(rsp_q.size())}, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
